// File: rtl/serial_negate_sched.sv
// serial_negate_sched: round-robin front end that shares one external
// bit-serial two's-complement negation core between two word requesters.
// A granted word is streamed LSB-first into the core through ser_x, the
// core's registered serial output ser_z is reassembled into a parallel
// result, and the result is returned tagged with the owning requester.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. reqN_ready is only ever high in IDLE for the round-robin winner and
// never while reset is asserted. out_valid holds, with out_data and out_id
// stable, until the consumer raises out_ready.
//
// rst_n is an active-high synchronous reset (the name is historical).
module serial_negate_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_id,
    input  logic         out_ready,
    output logic         ser_clr,
    output logic         ser_x,
    input  logic         ser_z,
    output logic [1:0]   dbg_state
);

    localparam int KW = $clog2(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [W-1:0]  sh;
    logic [W-1:0]  res;
    logic          last_grant;
    logic          winner;
    logic          grant0;
    logic          grant1;
    logic          in_reset;

    assign in_reset = rst_n;

    // Winner selection: a lone valid requester wins, contention goes to the
    // requester that was not granted last.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else begin
            winner = req1_valid;
        end
    end

    // Grants only in IDLE and never while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!in_reset && state == IDLE) begin
            grant0 = req0_valid && !winner;
            grant1 = req1_valid && winner;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Core control: clear on grant and throughout reset, stream the operand
    // LSB-first out of the shift register during SHIFT, zero otherwise.
    assign ser_clr   = in_reset | grant0 | grant1;
    assign ser_x     = !in_reset && (state == SHIFT) && sh[0];
    assign out_valid = !in_reset && (state == DONE);
    assign out_data  = res;
    assign dbg_state = state;

    // Sequencer: latch on grant, shift operand out and ser_z in, hold the
    // result in DONE until the consumer accepts it.
    always_ff @(posedge clk) begin
        if (in_reset) begin
            state      <= IDLE;
            k          <= '0;
            sh         <= '0;
            res        <= '0;
            out_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        sh         <= grant1 ? req1_data : req0_data;
                        out_id     <= grant1;
                        last_grant <= grant1;
                        k          <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh <= sh >> 1;
                    // ser_z lags ser_x by one cycle, so the first capture
                    // (result bit 0) happens on the second SHIFT cycle.
                    if (k != '0) begin
                        res <= {ser_z, res[W-1:1]};
                    end
                    if (k == K_LAST) begin
                        state <= DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    res   <= {ser_z, res[W-1:1]};
                    k     <= '0;
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_negate_sched.sv
// tb_serial_negate_sched: directed bench for serial_negate_sched with a
// behavioural copy/invert serial negation core attached to the ser_* ports.
// Drivers push {id, expected result} into exp_q at the grant; an
// independent monitor pops and compares on every output handshake.
module tb_serial_negate_sched;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_id;
  logic         out_ready;
  logic         ser_clr;
  logic         ser_x;
  logic         ser_z;
  logic [1:0]   dbg_state;

  logic [W:0] exp_q[$];
  int chk_cnt;
  int pass_cnt;

  serial_negate_sched #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .ser_clr    (ser_clr),
    .ser_x      (ser_x),
    .ser_z      (ser_z),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- serial core model (copy until first 1, then invert) ----
  logic core_inv;
  always @(posedge clk) begin
    if (ser_clr) begin
      core_inv <= 1'b0;
      ser_z    <= 1'b0;
    end else if (!core_inv) begin
      ser_z <= ser_x;
      if (ser_x) core_inv <= 1'b1;
    end else begin
      ser_z <= ~ser_x;
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {23'd0, out_id, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e[W-1:0]});
        check("out_id", {31'd0, out_id}, {31'd0, e[W]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word on requester id, wait (bounded) for its grant, record the
  // expected result, then drop valid. waited = cycles spent before grant.
  task automatic send(input logic id, input logic [W-1:0] data,
                      input logic [W-1:0] exp, output int waited);
    bit done;
    waited = 0;
    done = 0;
    if (id) begin req1_valid = 1'b1; req1_data = data; end
    else    begin req0_valid = 1'b1; req0_data = data; end
    while (!done) begin
      @(negedge clk);
      if ((id && req1_ready) || (!id && req0_ready)) begin
        exp_q.push_back({id, exp});
        done = 1;
      end else begin
        waited++;
        if (waited > 200) begin
          check("grant_timeout", 32'd0, 32'd1);
          done = 1;
        end
      end
    end
    tick();
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Wait until every expected result has been consumed; on return the DUT
  // sits in IDLE.
  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] bnd_in  [5] = '{8'h00, 8'h80, 8'h01, 8'hFF, 8'h7F};
  logic [W-1:0] bnd_exp [5] = '{8'h00, 8'h80, 8'hFF, 8'h01, 8'h81};
  logic [W-1:0] pat;

  initial begin
    int waited;
    int held_bad;
    int pulses;
    int ngr;
    int cyc;
    int gid  [4];
    int gcyc [4];
    int exp_gcyc [4] = '{0, 11, 22, 33};

    chk_cnt    = 0;
    pass_cnt   = 0;
    rst_n      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    out_ready  = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ser_clr", ser_clr, 1);
    check("rst_ser_x", ser_x, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_readies", {req1_ready, req0_ready}, 0);
    check("rst_state", dbg_state, 0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_ser_clr", ser_clr, 0);
    tick();

    // single op 0x05 -> 0xFB with exact timing
    req0_valid = 1'b1;
    req0_data  = 8'h05;
    @(negedge clk);
    check("c0_req0_ready", req0_ready, 1);
    check("c0_ser_clr", ser_clr, 1);
    exp_q.push_back({1'b0, 8'hFB});
    tick();
    req0_valid = 1'b0;
    pat = 8'h05;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check($sformatf("ser_x_c%0d", i + 1), ser_x, pat[i]);
      check($sformatf("ser_clr_c%0d", i + 1), ser_clr, 0);
    end
    @(negedge clk);
    check("c9_out_valid", out_valid, 0);
    @(negedge clk);
    check("c10_out_valid", out_valid, 1);
    wait_drain();

    // boundaries, alternating requesters
    for (int i = 0; i < 5; i++) begin
      send(i[0], bnd_in[i], bnd_exp[i], waited);
      check($sformatf("bnd%0d_wait", i), waited, 0);
      wait_drain();
    end

    // backpressure: 20 stall cycles with a pending requester
    out_ready = 1'b0;
    send(1'b0, 8'h7F, 8'h81, waited);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("bp_out_valid_rise", out_valid, 1);
    tick();
    req0_valid = 1'b1;
    req0_data  = 8'h01;
    held_bad = 0;
    pulses   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'h81 || out_id !== 1'b0) held_bad++;
      if (req0_ready || req1_ready) pulses++;
    end
    check("bp_held", held_bad, 0);
    check("bp_no_grant", pulses, 0);
    check("bp_data_end", out_data, 8'h81);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_no_grant", req0_ready, 0);
    @(negedge clk);
    check("bp_grant_after", req0_ready, 1);
    if (req0_ready) exp_q.push_back({1'b0, 8'hFF});
    tick();
    req0_valid = 1'b0;
    wait_drain();

    // reset in the middle of a word
    req0_valid = 1'b1;
    req0_data  = 8'h55;
    @(negedge clk);
    check("rm_grant", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n      = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 8'h02;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rm_ser_clr", ser_clr, 1);
      check("rm_out_valid", out_valid, 0);
      check("rm_no_ready", req1_ready, 0);
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rm_first_idle_grant", req1_ready, 1);
    if (req1_ready) exp_q.push_back({1'b1, 8'hFE});
    tick();
    req1_valid = 1'b0;
    wait_drain();

    // contention: both valid, requester 0 wins first (last grant was 1)
    req0_valid = 1'b1;
    req0_data  = 8'h03;
    req1_valid = 1'b1;
    req1_data  = 8'h10;
    ngr = 0;
    cyc = 0;
    while (ngr < 4 && cyc < 60) begin
      @(negedge clk);
      if (req0_ready) begin
        exp_q.push_back({1'b0, 8'hFD});
        gid[ngr] = 0;
        gcyc[ngr] = cyc;
        ngr++;
      end else if (req1_ready) begin
        exp_q.push_back({1'b1, 8'hF0});
        gid[ngr] = 1;
        gcyc[ngr] = cyc;
        ngr++;
      end
      cyc++;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("ct_grants", ngr, 4);
    for (int i = 0; i < ngr && i < 4; i++) begin
      check($sformatf("ct_id%0d", i), gid[i], i % 2);
      check($sformatf("ct_cyc%0d", i), gcyc[i], exp_gcyc[i]);
    end
    wait_drain();

    // lone requesters: 0, then 1, then 0 again with no wait
    send(1'b0, 8'h12, 8'hEE, waited);
    check("lone0_wait", waited, 0);
    wait_drain();
    send(1'b1, 8'h34, 8'hCC, waited);
    check("lone1_wait", waited, 0);
    wait_drain();
    send(1'b0, 8'h7E, 8'h82, waited);
    check("lone0b_wait", waited, 0);
    wait_drain();

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
